// File: rtl/obi_mem_sbr_shim.sv
// OBI subordinate endpoint driving a fixed-latency SRAM macro.
// Responses are buffered in an in-order FIFO sized by the outstanding-transaction credit limit.
module obi_mem_sbr_shim #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth = 8,
  parameter logic [AddrWidth-1:0] BaseAddr = 32'h0000_0000,
  parameter logic [AddrWidth-1:0] MemSizeBytes = 32'h0000_1000,
  parameter int unsigned MemLatency = 1,
  parameter int unsigned NumMaxTrans = 4,
  localparam int unsigned BeWidth = DataWidth / 8,
  localparam int unsigned MemAddrWidth = $clog2(MemSizeBytes / (DataWidth / 8))
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [AddrWidth-1:0]    addr_i,
  input  logic                    we_i,
  input  logic [BeWidth-1:0]      be_i,
  input  logic [DataWidth-1:0]    wdata_i,
  input  logic [IdWidth-1:0]      aid_i,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [DataWidth-1:0]    rdata_o,
  output logic [IdWidth-1:0]      rid_o,
  output logic                    err_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  output logic [BeWidth-1:0]      mem_be_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  input  logic [DataWidth-1:0]    mem_rdata_i
);

  localparam int unsigned CntWidth = $clog2(NumMaxTrans + 1);
  localparam int unsigned PtrWidth = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
  localparam int unsigned OffBits = $clog2(BeWidth);
  localparam int unsigned Last = MemLatency - 1;
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(NumMaxTrans);
  localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(NumMaxTrans - 1);

  logic [CntWidth-1:0]  cnt;
  logic [CntWidth-1:0]  fill;
  logic [PtrWidth-1:0]  wptr;
  logic [PtrWidth-1:0]  rptr;
  logic                 a_hs;
  logic                 r_hs;
  logic                 push;
  logic                 in_range;
  logic [AddrWidth:0]   offset;
  logic [DataWidth-1:0] push_data;

  logic                 pipe_valid [MemLatency];
  logic [IdWidth-1:0]   pipe_id    [MemLatency];
  logic                 pipe_we    [MemLatency];
  logic                 pipe_err   [MemLatency];

  logic [DataWidth-1:0] fifo_data  [NumMaxTrans];
  logic [IdWidth-1:0]   fifo_id    [NumMaxTrans];
  logic                 fifo_err   [NumMaxTrans];

  // One extra bit keeps the subtraction from wrapping near the top of the address space.
  assign offset   = {1'b0, addr_i} - {1'b0, BaseAddr};
  assign in_range = (addr_i >= BaseAddr) && (offset < {1'b0, MemSizeBytes});

  assign gnt_o = req_i && (cnt < CntMax) && !rst_n;
  assign a_hs  = req_i && gnt_o;
  assign r_hs  = rvalid_o && rready_i;

  assign mem_req_o   = a_hs && in_range;
  assign mem_we_o    = mem_req_o && we_i;
  assign mem_be_o    = mem_req_o ? be_i : '0;
  assign mem_wdata_o = mem_req_o ? wdata_i : '0;
  assign mem_addr_o  = mem_req_o ? offset[OffBits +: MemAddrWidth] : '0;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt <= '0;
    end else begin
      case ({a_hs, r_hs})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < MemLatency; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_id[i]    <= '0;
        pipe_we[i]    <= 1'b0;
        pipe_err[i]   <= 1'b0;
      end
    end else begin
      pipe_valid[0] <= a_hs;
      pipe_id[0]    <= aid_i;
      pipe_we[0]    <= we_i;
      pipe_err[0]   <= !in_range;
      for (int i = 1; i < MemLatency; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_id[i]    <= pipe_id[i-1];
        pipe_we[i]    <= pipe_we[i-1];
        pipe_err[i]   <= pipe_err[i-1];
      end
    end
  end

  // The last stage lines up with the SRAM read data.
  assign push      = pipe_valid[Last];
  assign push_data = (pipe_we[Last] || pipe_err[Last]) ? '0 : mem_rdata_i;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wptr <= '0;
      rptr <= '0;
      fill <= '0;
    end else begin
      if (push) begin
        wptr <= (wptr == PtrLast) ? '0 : wptr + 1'b1;
      end
      if (r_hs) begin
        rptr <= (rptr == PtrLast) ? '0 : rptr + 1'b1;
      end
      case ({push, r_hs})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wptr] <= push_data;
      fifo_id[wptr]   <= pipe_id[Last];
      fifo_err[wptr]  <= pipe_err[Last];
    end
  end

  assign rvalid_o = (fill != '0);
  assign rdata_o  = rvalid_o ? fifo_data[rptr] : '0;
  assign rid_o    = rvalid_o ? fifo_id[rptr] : '0;
  assign err_o    = rvalid_o ? fifo_err[rptr] : 1'b0;

endmodule

// File: tb/tb_obi_mem_sbr_shim.sv
// Bench for obi_mem_sbr_shim: two instances (latency 1 at base 0, latency 3 at the top of the
// address space) share one stimulus stream; each has an SRAM model and a transaction-level scoreboard.
module tb_obi_mem_sbr_shim;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req, we, rready;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [7:0]  aid;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    logic [63:0] obs;
    logic [63:0] exp;
  } chk_t;

  typedef struct {
    logic [7:0]  id;
    logic        err;
    logic [31:0] data;
    int          stamp;
  } exp_t;

  function automatic chk_t mk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_t c;
    c.tag = tag;
    c.obs = obs;
    c.exp = exp;
    return c;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_d
    localparam int unsigned Lat = (g == 0) ? 1 : 3;
    localparam logic [31:0] Base = (g == 0) ? 32'h0000_0000 : 32'hFFFF_F000;

    logic        gnt, rvalid, err, mem_req, mem_we;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [7:0]  rid;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_be;

    obi_mem_sbr_shim #(
      .BaseAddr(Base),
      .MemLatency(Lat)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata), .aid_i(aid),
      .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rid_o(rid), .err_o(err),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    // SRAM macro model: read data appears Lat cycles after the strobe
    logic [31:0] sram [1024] = '{default: '0};
    logic [31:0] rd_pipe [Lat] = '{default: '0};

    always @(posedge clk) begin
      if (mem_req) begin
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end else begin
          rd_pipe[0] <= sram[mem_addr];
        end
      end
      for (int i = 1; i < Lat; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[Lat-1];

    // Transaction-level reference: word memory, expected-response queue, outstanding count
    logic [31:0] ref_mem [int unsigned];
    exp_t        exp_q[$];
    chk_t        chk_q[$];
    int          outst = 0;
    int          max_out = 0;
    logic        hold = 1'b0;
    logic [41:0] snap = '0;

    always @(negedge clk) begin
      longint      off;
      bit          inr, hs;
      logic [31:0] idx, w;
      exp_t        e;
      if (rst_n) begin
        exp_q.delete();
        outst = 0;
        hold = 1'b0;
        chk_q.push_back(mk("reset_outputs", 64'({gnt, rvalid, mem_req, mem_we}), 64'(0)));
      end else begin
        off = longint'(addr) - longint'(Base);
        inr = (off >= 0) && (off < 64'h1000);
        idx = 32'(off) >> 2;
        hs  = req && gnt;
        chk_q.push_back(mk("gnt", 64'(gnt), 64'(req && (outst < 4))));
        chk_q.push_back(mk("mem_req", 64'(mem_req), 64'(hs && inr)));
        chk_q.push_back(mk("mem_cmd", 64'({mem_we, mem_be, mem_addr, mem_wdata}),
                           (hs && inr) ? 64'({we, be, idx[9:0], wdata}) : 64'(0)));
        if (hold)
          chk_q.push_back(mk("stable", 64'({rvalid, rid, err, rdata}), 64'(snap)));
        if (rvalid && rready) begin
          if (exp_q.size() == 0) begin
            chk_q.push_back(mk("pop_empty", 64'(1), 64'(0)));
          end else begin
            e = exp_q.pop_front();
            chk_q.push_back(mk("resp", 64'({rid, err, rdata}), 64'({e.id, e.err, e.data})));
            chk_q.push_back(mk("latency", 64'(cyc - e.stamp >= int'(Lat) + 1), 64'(1)));
          end
          outst--;
        end
        if (hs) begin
          w = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
          e.id    = aid;
          e.err   = !inr;
          e.stamp = cyc;
          e.data  = (inr && !we) ? w : 32'h0;
          if (inr && we) begin
            for (int b = 0; b < 4; b++)
              if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
            ref_mem[idx] = w;
          end
          exp_q.push_back(e);
          outst++;
          if (outst > max_out) max_out = outst;
        end
        hold = rvalid && !rready;
        snap = {rvalid, rid, err, rdata};
      end
    end
  end

  logic        gnt0, rvalid0, err0, mem_req0, mem_we0, gnt1;
  logic [7:0]  rid0;
  logic [31:0] rdata0;
  logic [9:0]  mem_addr0;
  assign gnt0      = gen_d[0].gnt;
  assign rvalid0   = gen_d[0].rvalid;
  assign err0      = gen_d[0].err;
  assign mem_req0  = gen_d[0].mem_req;
  assign mem_we0   = gen_d[0].mem_we;
  assign rid0      = gen_d[0].rid;
  assign rdata0    = gen_d[0].rdata;
  assign mem_addr0 = gen_d[0].mem_addr;
  assign gnt1      = gen_d[1].gnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Issue reads until n grants on dut0, then drop req
  task automatic grant_reads(input int n, input logic [7:0] id0);
    int got = 0;
    req = 1'b1; we = 1'b0; addr = 32'h8; aid = id0;
    for (int c = 0; c < 20 && got < n; c++) begin
      #1;
      if (gnt0) got++;
      nxt();
      aid = id0 + 8'(got);
    end
    req = 1'b0;
    check("grant_reads", 64'(got), 64'(n));
  endtask

  initial begin
    int k, got, n_gnt, n_str;
    logic g;
    req = 1'b1; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0; aid = 8'h0; rready = 1'b1;
    #2 rst_n = 1'b1;
    #1;
    check("rst_gnt", 64'(gnt0), 64'(0));
    check("rst_rvalid", 64'(rvalid0), 64'(0));
    check("rst_mem", 64'({mem_req0, mem_we0}), 64'(0));
    check("rst_resp", 64'({rdata0, rid0, err0}), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0; req = 1'b0;

    // single write then read-back
    nxt();
    req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h100; wdata = 32'hDEADBEEF; aid = 8'd3;
    #1;
    check("wr_gnt", 64'(gnt0), 64'(1));
    check("wr_mem", 64'({mem_req0, mem_we0, mem_addr0}), 64'({1'b1, 1'b1, 10'h40}));
    nxt(); req = 1'b0; #1;
    check("wr_rvalid_early", 64'(rvalid0), 64'(0));
    nxt(); #1;
    check("wr_resp", 64'({rvalid0, rid0, err0, rdata0}), 64'({1'b1, 8'd3, 1'b0, 32'h0}));
    req = 1'b1; we = 1'b0; aid = 8'd4; addr = 32'h100;
    #1;
    check("rd_mem", 64'({gnt0, mem_req0, mem_we0, mem_addr0}), 64'({1'b1, 1'b1, 1'b0, 10'h40}));
    nxt(); req = 1'b0;
    nxt(); #1;
    check("rd_resp", 64'({rvalid0, rid0, err0, rdata0}), 64'({1'b1, 8'd4, 1'b0, 32'hDEADBEEF}));

    // first byte past the range
    nxt();
    req = 1'b1; addr = 32'h1000; aid = 8'd7; we = 1'b0;
    #1;
    check("oor_gnt", 64'({gnt0, mem_req0}), 64'({1'b1, 1'b0}));
    nxt(); req = 1'b0;
    nxt(); #1;
    check("oor_resp", 64'({rvalid0, rid0, err0, rdata0}), 64'({1'b1, 8'd7, 1'b1, 32'h0}));

    // back-pressure: 6 reads with rready low
    nxt(); rready = 1'b0;
    nxt();
    k = 0; n_gnt = 0; req = 1'b1; we = 1'b0; addr = 32'h0; aid = 8'd0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (gnt0) n_gnt++;
      if (c >= 4) begin
        check("bp_gnt", 64'(gnt0), 64'(0));
        check("bp_head", 64'({rvalid0, rid0}), 64'({1'b1, 8'd0}));
      end
      g = gnt0;
      nxt();
      if (g) begin k++; aid = 8'(k); addr = 32'(k * 4); end
    end
    check("bp_grants", 64'(n_gnt), 64'(4));
    rready = 1'b1;
    #1;
    check("rel_gnt_first", 64'(gnt0), 64'(0));
    got = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      if (rvalid0) begin
        check("order", 64'(rid0), 64'(got));
        got++;
      end
      g = req && gnt0;
      if (c == 1) check("rel_gnt_resume", 64'(g), 64'(1));
      nxt();
      if (g) begin
        k++;
        if (k >= 6) req = 1'b0;
        else begin aid = 8'(k); addr = 32'(k * 4); end
      end
      #1;
    end
    check("order_count", 64'(got), 64'(6));

    // A and R handshake together at cnt = 3
    repeat (6) nxt();
    rready = 1'b0;
    grant_reads(3, 8'd10);
    nxt(); nxt();
    req = 1'b1; aid = 8'd13; rready = 1'b1;
    #1;
    check("sim_hs", 64'({gnt0, rvalid0}), 64'({1'b1, 1'b1}));
    nxt(); #1;
    check("sim_gnt_next", 64'(gnt0), 64'(1));
    req = 1'b0;
    repeat (10) nxt();

    // reset with three responses buffered
    rready = 1'b0;
    grant_reads(3, 8'd20);
    repeat (3) nxt();
    #1;
    check("pre_rst_rvalid", 64'(rvalid0), 64'(1));
    rst_n = 1'b1; req = 1'b1;
    #1;
    check("in_rst", 64'({rvalid0, gnt0}), 64'(0));
    nxt(); #1;
    check("in_rst2", 64'({rvalid0, gnt0}), 64'(0));
    nxt();
    rst_n = 1'b0; rready = 1'b1; req = 1'b1; we = 1'b0; aid = 8'd9; addr = 32'h100;
    #1;
    check("post_rst_gnt", 64'(gnt0), 64'(1));
    nxt(); req = 1'b0; #1;
    check("post_rst_empty", 64'(rvalid0), 64'(0));
    nxt(); #1;
    check("post_rst_resp", 64'({rvalid0, rid0, err0, rdata0}), 64'({1'b1, 8'd9, 1'b0, 32'hDEADBEEF}));

    // random traffic, then continuous streaming into the latency-3 instance
    n_str = 0;
    for (int c = 0; c < 420; c++) begin
      nxt();
      we    = 1'($urandom_range(0, 1));
      be    = 4'($urandom);
      wdata = $urandom;
      aid   = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       addr = 32'($urandom_range(0, 32'h1FFF));
        1:       addr = 32'hFFFF_E000 + 32'($urandom_range(0, 32'h1FFF));
        2:       addr = 32'($urandom_range(0, 63)) * 4;
        default: addr = 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
      endcase
      if (c < 300) begin
        req    = ($urandom_range(0, 9) < 7);
        rready = ($urandom_range(0, 9) < 6);
      end else if (c < 360) begin
        req    = 1'b1;
        rready = 1'b1;
        addr   = 32'hFFFF_F000 + 32'($urandom_range(0, 1023)) * 4;
      end else begin
        req    = 1'b0;
        rready = 1'b1;
      end
      #1;
      if (c >= 330 && c < 360 && gnt1) n_str++;
    end
    check("stream_grants", 64'(n_str), 64'(24));
    check("d1_max_outstanding", 64'(gen_d[1].max_out), 64'(4));
    check("d0_all_returned", 64'(gen_d[0].exp_q.size()), 64'(0));
    check("d1_all_returned", 64'(gen_d[1].exp_q.size()), 64'(0));

    for (int i = 0; i < gen_d[0].chk_q.size(); i++)
      check({"d0_", gen_d[0].chk_q[i].tag}, gen_d[0].chk_q[i].obs, gen_d[0].chk_q[i].exp);
    for (int i = 0; i < gen_d[1].chk_q.size(); i++)
      check({"d1_", gen_d[1].chk_q[i].tag}, gen_d[1].chk_q[i].obs, gen_d[1].chk_q[i].exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
